// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: instruction-type codes, sequencer states, reset defaults
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        SEQ_FETCH  = 3'd0,
        SEQ_DECODE = 3'd1,
        SEQ_EXEC   = 3'd2,
        SEQ_MEM    = 3'd3,
        SEQ_WB     = 3'd4,
        SEQ_HALT   = 3'd5,
        SEQ_ERR    = 3'd6
    } seq_state_t;

    localparam logic [15:0] SEQ_RESET_IP    = 16'h3000;
    localparam int          SEQ_MEM_TIMEOUT = 255;
    localparam int          SEQ_WAIT_W      = 8;

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - counts unacknowledged memory wait cycles and flags the timeout cycle
module seq_wait_timer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = SEQ_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ack,
    input  logic clear,
    output logic timeout
);

    localparam logic [SEQ_WAIT_W-1:0] LAST = SEQ_WAIT_W'(TIMEOUT - 1);

    logic [SEQ_WAIT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (active && !ack) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th waiting cycle; an ack in that same cycle suppresses it.
    assign timeout = active && !ack && (cnt == LAST);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - CPU fetch/decode/execute/memory/writeback sequencer
// Optional retired-instruction counter enabled by CPU_SEQ_CTRL_PERF_EN.
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_IP    = SEQ_RESET_IP,
    parameter int          MEM_TIMEOUT = SEQ_MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_wb,
    input  logic        dec_halt,
    input  logic [15:0] ea,
    input  logic [15:0] st_data,
    input  logic [15:0] next_ip,
    output logic [15:0] inst,
    output logic [15:0] ip,
    output logic [15:0] ld_data,
    output logic        reg_we,
    output logic        cc_we,
    output logic        halted,
    output logic        err,
    output logic [15:0] retired
);

    seq_state_t state, state_next;
    logic       wait_active;
    logic       timeout;

    assign wait_active = (state == SEQ_FETCH) || (state == SEQ_MEM);

    seq_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .active  (wait_active),
        .ack     (mem_ack),
        .clear   (state_next != state),
        .timeout (timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEQ_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEQ_FETCH: begin
                if (mem_ack) begin
                    state_next = SEQ_DECODE;
                end else if (timeout) begin
                    state_next = SEQ_ERR;
                end
            end
            SEQ_DECODE: state_next = SEQ_EXEC;
            SEQ_EXEC: begin
                if (dec_halt) begin
                    state_next = SEQ_HALT;
                end else if (dec_load || dec_store) begin
                    state_next = SEQ_MEM;
                end else begin
                    state_next = SEQ_WB;
                end
            end
            SEQ_MEM: begin
                if (mem_ack) begin
                    state_next = SEQ_WB;
                end else if (timeout) begin
                    state_next = SEQ_ERR;
                end
            end
            SEQ_WB:   state_next = SEQ_FETCH;
            SEQ_HALT: state_next = SEQ_HALT;
            SEQ_ERR:  state_next = SEQ_ERR;
            default:  state_next = SEQ_FETCH;
        endcase
    end

    // State already sits at FETCH during reset, so the request is gated by rst directly.
    always_comb begin
        mem_req  = wait_active && !rst;
        mem_we   = (state == SEQ_MEM) && dec_store && !dec_load;
        mem_addr = (state == SEQ_MEM) ? ea : ip;
        reg_we   = (state == SEQ_WB) && dec_wb;
        cc_we    = (state == SEQ_WB) && dec_wb;
        halted   = (state == SEQ_HALT);
        err      = (state == SEQ_ERR);
    end

    assign mem_wdata = st_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip      <= RESET_IP;
            inst    <= '0;
            ld_data <= '0;
        end else begin
            if (state == SEQ_FETCH && mem_ack) begin
                inst <= mem_rdata;
            end
            if (state == SEQ_MEM && mem_ack && dec_load) begin
                ld_data <= mem_rdata;
            end
            if (state == SEQ_WB) begin
                ip <= next_ip;
            end
        end
    end

`ifdef CPU_SEQ_CTRL_PERF_EN
    logic [15:0] retired_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (state == SEQ_WB) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end

    assign retired = retired_cnt;
`else
    assign retired = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - scoreboard bench for cpu_seq_ctrl directed scenarios
module tb_cpu_seq_ctrl;

`ifdef CPU_SEQ_CTRL_PERF_EN
    localparam logic [15:0] RET_ONE = 16'd1;
`else
    localparam logic [15:0] RET_ONE = 16'd0;
`endif

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        dec_load = 1'b0, dec_store = 1'b0, dec_wb = 1'b0, dec_halt = 1'b0;
    logic [15:0] ea = '0, st_data = '0, next_ip = '0;
    logic [15:0] inst, ip, ld_data, retired;
    logic        reg_we, cc_we, halted, err;

    xfer_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fetch_credit = 0;
    int          fetch_delay = 0;
    int          mem_delay = 0;
    bit          mem_en = 1'b0;
    int          wcnt = 0;
    logic [15:0] fetch_word = 16'h1042;
    logic [15:0] load_word = 16'h0000;
    logic        is_fetch;

    cpu_seq_ctrl #(
        .RESET_IP    (16'h3000),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .dec_load  (dec_load),
        .dec_store (dec_store),
        .dec_wb    (dec_wb),
        .dec_halt  (dec_halt),
        .ea        (ea),
        .st_data   (st_data),
        .next_ip   (next_ip),
        .inst      (inst),
        .ip        (ip),
        .ld_data   (ld_data),
        .reg_we    (reg_we),
        .cc_we     (cc_we),
        .halted    (halted),
        .err       (err),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory model: fetches are acked only while credit remains, after fetch_delay waits.
    assign is_fetch  = (mem_addr == ip);
    assign mem_rdata = is_fetch ? fetch_word : load_word;

    always_comb begin
        mem_ack = 1'b0;
        if (mem_req) begin
            if (is_fetch) begin
                mem_ack = (fetch_credit > 0) && (wcnt >= fetch_delay);
            end else begin
                mem_ack = mem_en && (wcnt >= mem_delay);
            end
        end
    end

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) wcnt <= 0;
        else                            wcnt <= wcnt + 1;
        if (!rst && mem_req && mem_ack && is_fetch) fetch_credit <= fetch_credit - 1;
    end

    always @(negedge clk) begin
        xfer_t e;
        if (!rst && mem_req && mem_ack) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("xfer_addr", 32'(mem_addr), 32'(e.addr));
                check("xfer_we", 32'(mem_we), 32'(e.we));
                if (e.we) check("xfer_wdata", 32'(mem_wdata), 32'(e.wdata));
            end
        end
    end

    task automatic push_x(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        exp_q.push_back('{we: we, addr: addr, wdata: wdata});
    endtask

    task automatic set_dec(input logic ld, input logic st, input logic wb, input logic hl,
                           input logic [15:0] a, input logic [15:0] sd, input logic [15:0] nip);
        dec_load = ld; dec_store = st; dec_wb = wb; dec_halt = hl;
        ea = a; st_data = sd; next_ip = nip;
    endtask

    task automatic start(input int credit);
        @(posedge clk); #1;
        rst = 1'b1;
        fetch_credit = credit;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int first, aux, cnt, last;

        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ip", 32'(ip), 32'h3000);
        check("rst_inst", 32'(inst), 32'd0);
        check("rst_ld_data", 32'(ld_data), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_flags", {29'd0, err, halted, reg_we | cc_we}, 32'd0);

        // Zero-wait ADD
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h3001);
        push_x(1'b0, 16'h3000, 16'h0000);
        start(1);
        first = 0; aux = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (reg_we && first == 0) begin first = c; aux = int'(cc_we); end
        end
        check("add_we_cycle", first, 4);
        check("add_cc_we", aux, 1);
        check("add_ip", 32'(ip), 32'h3001);
        check("add_retired", 32'(retired), 32'(RET_ONE));
        check("add_inst", 32'(inst), 32'(fetch_word));
        check("add_refetch_addr", 32'(mem_addr), 32'h3001);

        // LDR with 3-cycle ack delay
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 16'h4000, 16'h0000, 16'h3001);
        mem_en = 1'b1; mem_delay = 3; load_word = 16'hBEEF;
        push_x(1'b0, 16'h3000, 16'h0000);
        push_x(1'b0, 16'h4000, 16'h0000);
        start(1);
        first = 0; cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (mem_req && !mem_ack && mem_addr == 16'h4000 && !mem_we) cnt++;
            if (reg_we && first == 0) first = c;
        end
        check("ldr_hold_cycles", cnt, 3);
        check("ldr_we_cycle", first, 8);
        check("ldr_data", 32'(ld_data), 32'hBEEF);

        // STR
        set_dec(1'b0, 1'b1, 1'b0, 1'b0, 16'h4002, 16'h1234, 16'h3001);
        mem_delay = 0;
        push_x(1'b0, 16'h3000, 16'h0000);
        push_x(1'b1, 16'h4002, 16'h1234);
        start(1);
        first = 0; cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (reg_we) cnt++;
            if (ip == 16'h3001 && first == 0) first = c;
        end
        check("str_reg_we_count", cnt, 0);
        check("str_ip_cycle", first, 6);
        check("str_wdata", 32'(mem_wdata), 32'h1234);
        check("str_retired", 32'(retired), 32'(RET_ONE));

        // HALT
        set_dec(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h3001);
        push_x(1'b0, 16'h3000, 16'h0000);
        start(1);
        first = 0; cnt = 0; aux = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (halted && first == 0) first = c;
            if (c > 4 && mem_req) cnt++;
            if (reg_we || cc_we) aux++;
        end
        check("halt_cycle", first, 4);
        check("halt_req_count", cnt, 0);
        check("halt_strobes", aux, 0);
        check("halt_sticky", {30'd0, halted, err}, 32'd2);

        // Fetch ack withheld: timeout after 8 wait cycles
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h3001);
        start(0);
        first = 0; last = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (mem_req) last = c;
            if (err && first == 0) first = c;
        end
        check("tmo_err_cycle", first, 9);
        check("tmo_last_req", last, 8);
        check("tmo_final", {30'd0, err, mem_req}, 32'd2);

        // Ack on the 8th wait cycle wins over timeout
        fetch_delay = 7;
        push_x(1'b0, 16'h3000, 16'h0000);
        start(1);
        first = 0; cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (err) cnt++;
            if (reg_we && first == 0) first = c;
        end
        fetch_delay = 0;
        check("late_ack_err", cnt, 0);
        check("late_ack_we_cycle", first, 11);

        // Reset while waiting in MEM
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 16'h4000, 16'h0000, 16'h3001);
        mem_en = 1'b0;
        push_x(1'b0, 16'h3000, 16'h0000);
        start(1);
        for (int c = 1; c <= 6; c++) @(negedge clk);
        check("mid_req_before", 32'(mem_req), 32'd1);
        check("mid_addr_before", 32'(mem_addr), 32'h4000);
        #2 rst = 1'b1;
        #1 check("mid_req_dropped", 32'(mem_req), 32'd0);
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h3001);
        mem_en = 1'b1;
        fetch_credit = 1;
        push_x(1'b0, 16'h3000, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req", 32'(mem_req), 32'd1);
        check("post_rst_addr", 32'(mem_addr), 32'h3000);
        check("post_rst_we", 32'(mem_we), 32'd0);
        check("post_rst_retired", 32'(retired), 32'd0);
        first = 0;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (reg_we && first == 0) first = c;
        end
        check("post_rst_we_cycle", first, 4);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
  - RESET_IP, 16'h3000, instruction pointer value loaded at reset.
  - MEM_TIMEOUT, 255, maximum cycles to wait for mem_ack (1..255).
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  - clk, in, 1, single clock, rising edge.
  - rst, in, 1, asynchronous active-high reset.
  - mem_req, out, 1, memory request, held high until acknowledged.
  - mem_we, out, 1, 1 = write, 0 = read; valid while mem_req is high.
  - mem_addr, out, 16, memory address.
  - mem_wdata, out, 16, store data (equals st_data).
  - mem_ack, in, 1, memory accepts or completes the request this cycle.
  - mem_rdata, in, 16, read data, valid when mem_ack is high.
  - dec_load, in, 1, decoded instruction is a load.
  - dec_store, in, 1, decoded instruction is a store.
  - dec_wb, in, 1, decoded instruction writes a register.
  - dec_halt, in, 1, decoded instruction is HALT/TRAP x25.
  - ea, in, 16, effective address from the execute datapath.
  - st_data, in, 16, store data from the register file.
  - next_ip, in, 16, next instruction pointer from the execute datapath.
  - inst, out, 16, latched current instruction.
  - ip, out, 16, current instruction pointer.
  - ld_data, out, 16, latched load data.
  - reg_we, out, 1, register-file write enable, one-cycle pulse.
  - cc_we, out, 1, n/z/p update enable, one-cycle pulse.
  - halted, out, 1, processor is stopped by HALT.
  - err, out, 1, sticky memory-timeout error.
  - retired, out, 16, retired-instruction count (see Configuration).

Function
REQ-003 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB, HALT and ERR, one-hot or binary encoded.
REQ-004 In FETCH the block SHALL drive mem_req=1, mem_we=0 and mem_addr=ip.
  - On a cycle with mem_ack=1: inst <= mem_rdata, then go to DECODE.
REQ-005 DECODE SHALL last exactly one cycle with no outputs asserted; it gives the decoder and register file time to settle. Then go to EXEC.
REQ-006 EXEC SHALL last one cycle and branch as follows:
  - dec_halt -> HALT.
  - dec_load or dec_store -> MEM.
  - otherwise -> WB.
  - If dec_load and dec_store are both high, load takes priority.
REQ-007 In MEM the block SHALL drive mem_req=1, mem_addr=ea and mem_we=dec_store.
  - On mem_ack: ld_data <= mem_rdata (loads only), then go to WB.
REQ-008 WB SHALL last one cycle, then return to FETCH. During it:
  - reg_we = dec_wb.
  - cc_we = dec_wb.
  - ip <= next_ip.
  - retired increments.
REQ-009 A minimal non-memory instruction SHALL take 4 cycles (FETCH with zero-wait ack, DECODE, EXEC, WB); a load or store SHALL take 5.
REQ-010 mem_addr and mem_we SHALL stay stable while mem_req=1 and mem_ack=0.
  - mem_req SHALL drop in the cycle after the ack.
REQ-011 A wait counter SHALL count cycles spent in FETCH or MEM without mem_ack.
  - When it reaches MEM_TIMEOUT: go to ERR, set err=1, drop mem_req.
  - The counter clears on every state change.
REQ-012 An ack arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL win: the access completes and no error is raised.
REQ-013 HALT and ERR SHALL be terminal until reset.
  - halted=1 in HALT; mem_req=0, reg_we=0, cc_we=0 in both.
REQ-014 mem_ack in any state other than FETCH or MEM SHALL be ignored.
REQ-015 ip SHALL wrap modulo 2^16, since it is taken verbatim from next_ip.
  - retired SHALL wrap from 16'hFFFF to 0.

Reset
REQ-016 While rst=1, the block SHALL asynchronously force:
  - state = FETCH, ip = RESET_IP.
  - inst = 0, ld_data = 0, retired = 0, wait counter = 0.
  - err = 0, halted = 0, and all strobes and mem_req = 0.
REQ-017 Reset asserted mid-access SHALL abandon the transaction immediately.
  - The first request after reset release SHALL be a fetch from RESET_IP, issued in the first cycle after release.

Configuration
REQ-018 With CPU_SEQ_CTRL_PERF_EN defined, retired SHALL count completed WB cycles.
  - Without the macro, retired SHALL be tied to 16'h0000 and its counter SHALL not be synthesized.

Structure
REQ-019 The state encoding typedef, RESET_IP default and MEM_TIMEOUT default SHALL live in the shared CPU package (cpu_pkg), alongside the existing instruction-type codes.
REQ-020 The wait counter and timeout compare SHALL be a sub-module, seq_wait_timer. All other logic is flat.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Zero-wait ADD (dec_wb=1): after reset, reg_we pulses in cycle 4, ip goes 3000 -> next_ip=3001, retired=1.
  - LDR with ea=16'h4000, 3-cycle ack delay, mem_rdata=16'hBEEF: mem_addr=4000 and mem_we=0 held for 3 cycles, then ld_data=BEEF and reg_we pulses.
  - STR with ea=16'h4002, st_data=16'h1234: mem_we=1, mem_wdata=1234, reg_we stays 0.
  - HALT decoded: halted=1, mem_req stays 0 for 20 further cycles.
  - mem_ack withheld, MEM_TIMEOUT=8: err=1 after 8 wait cycles, mem_req=0; a second case with ack arriving on cycle 8 raises no error.
  - rst pulsed while waiting in MEM: mem_req drops immediately; after release the fetch is issued at 16'h3000 and retired=0.
